// File: rtl/wb_write_port.sv
// Register-file write front end: merges the never-stalled pipeline writeback with
// a queued long-latency result stream and exports per-register pending bits.
module wb_write_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_pipe_we,
    input  logic [ADDR_W-1:0]        i_pipe_waddr,
    input  logic [DATA_W-1:0]        i_pipe_wdata,
    input  logic                     i_lu_valid,
    output logic                     o_lu_ready,
    input  logic [ADDR_W-1:0]        i_lu_waddr,
    input  logic [DATA_W-1:0]        i_lu_wdata,
    output logic                     o_we,
    output logic [ADDR_W-1:0]        o_waddr,
    output logic [DATA_W-1:0]        o_wdata,
    output logic [31:0]              o_pending,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PTR_W:0]      head_q, tail_q;
    logic [DEPTH-1:0]    live_q, live_d;
    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic                we_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [PTR_W:0]      count;
    logic [PTR_W-1:0]    head_idx, tail_idx;
    logic                pipe_eff, lu_ready, accept, pop, enq_live;
    logic [31:0]         pending;

    assign count    = tail_q - head_q;
    assign head_idx = head_q[PTR_W-1:0];
    assign tail_idx = tail_q[PTR_W-1:0];
    assign pipe_eff = i_pipe_we && (i_pipe_waddr != '0);

    // Valid/ready: a long-latency result transfers on any rising edge where
    // i_lu_valid and o_lu_ready are both high; ready depends only on registered
    // occupancy, so a full queue refuses even in a cycle where it pops.
    assign lu_ready = (count < (PTR_W+1)'(DEPTH));
    assign accept   = i_lu_valid && lu_ready;
    assign pop      = !pipe_eff && (count != '0);
    // A same-cycle pipeline write to the same register is younger and wins.
    assign enq_live = (i_lu_waddr != '0) && !(pipe_eff && (i_lu_waddr == i_pipe_waddr));

    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (tail_idx == PTR_W'(i))) begin
                live_d[i] = enq_live;
            end else if ((pop && (head_idx == PTR_W'(i))) ||
                         (pipe_eff && (addr_q[i] == i_pipe_waddr))) begin
                live_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) pending[addr_q[i]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            live_q <= '0;
        end else begin
            live_q <= live_d;
            if (accept) tail_q <= tail_q + 1'b1;
            if (pop)    head_q <= head_q + 1'b1;
        end
    end

    // Payload storage needs no reset: it is only observed through live bits.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q[tail_idx] <= i_lu_waddr;
            data_q[tail_idx] <= i_lu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (pipe_eff) begin
            we_q    <= 1'b1;
            waddr_q <= i_pipe_waddr;
            wdata_q <= i_pipe_wdata;
        end else if (pop && live_q[head_idx]) begin
            we_q    <= 1'b1;
            waddr_q <= addr_q[head_idx];
            wdata_q <= data_q[head_idx];
        end else begin
            we_q    <= 1'b0;
        end
    end

    assign o_lu_ready = lu_ready;
    assign o_we       = we_q;
    assign o_waddr    = waddr_q;
    assign o_wdata    = wdata_q;
    assign o_pending  = pending;
    assign o_count    = count;

endmodule

// File: tb/tb_wb_write_port.sv
// Self-checking bench for wb_write_port: queue-based reference model compared every
// cycle, write-order scoreboard, and directed literal checks for the key scenarios.
module tb_wb_write_port;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              pipe_we = 1'b0;
  logic [ADDR_W-1:0] pipe_waddr = '0;
  logic [DATA_W-1:0] pipe_wdata = '0;
  logic              lu_valid = 1'b0;
  logic [ADDR_W-1:0] lu_waddr = '0;
  logic [DATA_W-1:0] lu_wdata = '0;
  logic              o_lu_ready, o_we;
  logic [ADDR_W-1:0] o_waddr;
  logic [DATA_W-1:0] o_wdata;
  logic [31:0]       o_pending;
  logic [CW-1:0]     o_count;

  wb_write_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_pipe_we(pipe_we), .i_pipe_waddr(pipe_waddr), .i_pipe_wdata(pipe_wdata),
    .i_lu_valid(lu_valid), .o_lu_ready(o_lu_ready),
    .i_lu_waddr(lu_waddr), .i_lu_wdata(lu_wdata),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_pending(o_pending), .o_count(o_count)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              lu_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic              exp_we = 1'b0;
  logic [ADDR_W-1:0] exp_waddr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (lu_q[i]) if (lu_q[i].live) p[lu_q[i].addr] = 1'b1;
    return p;
  endfunction

  task automatic model_step();
    bit   peff, acc;
    ent_t e;
    peff = pipe_we && (pipe_waddr != 0);
    acc  = lu_valid && (lu_q.size() < DEPTH);
    if (peff) begin
      exp_we = 1'b1; exp_waddr = pipe_waddr; exp_wdata = pipe_wdata;
      exp_q.push_back({pipe_waddr, pipe_wdata});
    end else if (lu_q.size() > 0) begin
      e = lu_q.pop_front();
      exp_we = e.live;
      if (e.live) begin
        exp_waddr = e.addr; exp_wdata = e.data;
        exp_q.push_back({e.addr, e.data});
      end
    end else begin
      exp_we = 1'b0;
    end
    if (peff) foreach (lu_q[i]) if (lu_q[i].addr == pipe_waddr) lu_q[i].live = 1'b0;
    if (acc) begin
      e.live = (lu_waddr != 0) && !(peff && lu_waddr == pipe_waddr);
      e.addr = lu_waddr;
      e.data = lu_wdata;
      lu_q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      lu_q.delete(); exp_q.delete();
      exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
    end else begin
      model_step();
    end
  end

  // ---------------- compare process + scoreboard ----------------
  initial forever begin
    logic [ADDR_W+DATA_W-1:0] w;
    @(negedge clk);
    if (check_en) begin
      check("we", o_we, exp_we);
      check("waddr", o_waddr, exp_waddr);
      check("wdata", o_wdata, exp_wdata);
      check("count", o_count, lu_q.size());
      check("ready", o_lu_ready, lu_q.size() < DEPTH);
      check("pending", o_pending, model_pending());
      if (o_we) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("sb_write", {o_waddr, o_wdata}, w);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic pwe, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                       input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, o_we, 0);
    check({tag, "_waddr"}, o_waddr, 0);
    check({tag, "_wdata"}, o_wdata, 0);
    check({tag, "_count"}, o_count, 0);
    check({tag, "_pending"}, o_pending, 0);
    check({tag, "_ready"}, o_lu_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] sdata [10];

  initial begin
    idle();
    repeat (2) cycle();
    check_reset_values("rst");
    reset_n = 1'b1;
    check_en = 1'b1;
    cycle();

    // reset and pipeline latency
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    cycle();
    check("p_we", o_we, 1); check("p_waddr", o_waddr, 5); check("p_wdata", o_wdata, 32'hDEADBEEF);
    idle();
    cycle();
    check("p_we_once", o_we, 0); check("p_hold_addr", o_waddr, 5); check("p_hold_data", o_wdata, 32'hDEADBEEF);
    drive(1'b1, 5'd0, 32'h1, 1'b0, '0, '0);
    cycle();
    check("r0_we", o_we, 0);
    idle();
    cycle();

    // queue fill behind a busy pipeline, then drain
    for (int k = 0; k < 4; k++) begin
      check("fill_ready", o_lu_ready, 1);
      drive(1'b1, 5'd1, 32'h1000 + k, 1'b1, ADDR_W'(8 + k), 32'h80 + 32'h10 * k);
      cycle();
    end
    check("full_count", o_count, 4); check("full_ready", o_lu_ready, 0);
    check("full_pending", o_pending, 32'h0000_0F00);
    idle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("drain_we", o_we, 1);
      check("drain_addr", o_waddr, 8 + k);
      check("drain_data", o_wdata, 32'h80 + 32'h10 * k);
    end
    check("drain_pending", o_pending, 0); check("drain_ready", o_lu_ready, 1);
    check("drain_count", o_count, 0);

    // kill of a queued entry
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h77);
    cycle();
    check("kill_pend_set", o_pending[7], 1);
    drive(1'b1, 5'd7, 32'h55, 1'b0, '0, '0);
    cycle();
    check("kill_we", o_we, 1); check("kill_addr", o_waddr, 7); check("kill_data", o_wdata, 32'h55);
    check("kill_pend_clr", o_pending[7], 0); check("kill_count", o_count, 1);
    idle();
    cycle();
    check("killed_pop_we", o_we, 0); check("killed_pop_count", o_count, 0);
    check("killed_hold_data", o_wdata, 32'h55);

    // same-cycle collision
    drive(1'b1, 5'd3, 32'h44, 1'b1, 5'd3, 32'h33);
    cycle();
    check("coll_addr", o_waddr, 3); check("coll_data", o_wdata, 32'h44);
    check("coll_pending", o_pending, 0); check("coll_count", o_count, 1);
    idle();
    cycle();
    check("coll_no_write", o_we, 0); check("coll_pending2", o_pending, 0);

    // streaming with wrap and simultaneous accept/pop
    for (int i = 0; i < 10; i++) sdata[i] = $urandom;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(1'b0, '0, '0, 1'b1, ADDR_W'(i + 1), sdata[i]);
      else idle();
      cycle();
      check("stream_count_le1", o_count <= 1, 1);
      if (i == 0) check("stream_first_we", o_we, 0);
      else begin
        check("stream_we", o_we, 1);
        check("stream_addr", o_waddr, i);
        check("stream_data", o_wdata, sdata[i-1]);
      end
    end
    cycle();
    check("stream_end_we", o_we, 0); check("stream_end_count", o_count, 0);

    // reset mid-operation
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd2, 32'h200 + k, 1'b1, ADDR_W'(20 + k), 32'hA0 + k);
      cycle();
    end
    check("mid_count", o_count, 3); check("mid_pending", o_pending, 32'h0070_0000);
    idle();
    #1 reset_n = 1'b0;
    #1 check_reset_values("midrst");
    #1 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("post_rst_we", o_we, 0);
    end

    // randomized traffic checked by the model
    for (int n = 0; n < 3000; n++) begin
      bit hold;
      hold = lu_valid && !o_lu_ready;
      pipe_we    = ($urandom_range(0, 99) < ((n < 1500) ? 50 : 20));
      pipe_waddr = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      pipe_wdata = $urandom;
      if (!hold) begin
        lu_valid = ($urandom_range(0, 99) < 60);
        lu_waddr = ADDR_W'($urandom_range(0, 7));
        lu_wdata = $urandom;
      end
      cycle();
      if ($urandom_range(0, 299) == 0) begin
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end
    idle();
    repeat (DEPTH + 2) cycle();
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
